// File: rtl/csr_regbank_pkg.sv
// ---------------------------------------------------------------------------
// csr_regbank_pkg
// Shared definitions for the CSR register-bank responder:
//   - byte offsets of each register relative to BASE_ADDR
//   - responder FSM state encoding
//   - byte-lane merge helper used for strobed register writes
// ---------------------------------------------------------------------------
package csr_regbank_pkg;

    localparam logic [4:0] OFF_ID      = 5'h00;
    localparam logic [4:0] OFF_CTRL    = 5'h04;
    localparam logic [4:0] OFF_STATUS  = 5'h08;
    localparam logic [4:0] OFF_EVENT   = 5'h0C;
    localparam logic [4:0] OFF_SCRATCH = 5'h10;
    localparam logic [4:0] OFF_COUNT   = 5'h14;
    localparam logic [4:0] REG_SPAN    = 5'h18;

    typedef enum logic {
        CSR_RB_IDLE = 1'b0,
        CSR_RB_RESP = 1'b1
    } csr_rb_state_e;

    // One byte lane of a strobed write: take the new byte when its enable is set.
    function automatic logic [7:0] csr_merge_byte(
        input logic [7:0] old_b,
        input logic [7:0] new_b,
        input logic       en
    );
        return en ? new_b : old_b;
    endfunction

endpackage

// File: rtl/csr_sat_counter.sv
// ---------------------------------------------------------------------------
// csr_sat_counter
// Saturating up-counter with synchronous clear.
//   clk, rst : clock and synchronous active-high reset
//   inc      : add one this cycle (ignored once the counter is all-ones)
//   clr      : clear this cycle; clr together with inc leaves the count at 1
//   count_o  : current count
// ---------------------------------------------------------------------------
module csr_sat_counter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clr,
    output logic [DATA_W-1:0] count_o
);

    logic [DATA_W-1:0] count_q;
    logic [DATA_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            // The event that coincides with a clear is counted, not lost.
            count_d = inc ? DATA_W'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + DATA_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/csr_regbank_slave.sv
// ---------------------------------------------------------------------------
// csr_regbank_slave
// Responder end of the CSR request/response channel. Accepts one request at a
// time, decodes it against a six-register map and returns a registered
// response that is held stable until rsp_ready.
//   clk, rst         : clock, synchronous active-high reset
//   req_*            : request channel (valid/ready, write, addr, wdata,
//                      wstrb, priv)
//   rsp_*            : response channel (valid/ready, rdata, fault,
//                      side_effect)
//   ctrl_o           : CTRL register contents
//   hw_status_i      : live status, sampled when a STATUS read is accepted
//   hw_event_i       : per-bit event pulses feeding EVENT and COUNT
// Register map (byte offset from BASE_ADDR):
//   0x00 ID (RO), 0x04 CTRL (RW, privileged write), 0x08 STATUS (RO),
//   0x0C EVENT (sticky, W1C), 0x10 SCRATCH (RW), 0x14 COUNT (RO, read-clear)
// ---------------------------------------------------------------------------
module csr_regbank_slave
    import csr_regbank_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                PRIV_W      = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter logic [31:0]       ID_VALUE    = 32'hCA5B_0001,
    parameter logic [PRIV_W-1:0] MIN_WR_PRIV = PRIV_W'(3)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    input  logic [PRIV_W-1:0]     req_priv,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_fault,
    output logic                  rsp_side_effect,
    output logic [DATA_W-1:0]     ctrl_o,
    input  logic [DATA_W-1:0]     hw_status_i,
    input  logic [DATA_W-1:0]     hw_event_i
);

    localparam int NB = DATA_W / 8;

    csr_rb_state_e     state_q, state_d;
    logic [DATA_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] scratch_q, scratch_d;
    logic [DATA_W-1:0] event_q, event_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic              rsp_side_effect_q, rsp_side_effect_d;

    logic [DATA_W-1:0] count_val;
    logic              accept;
    logic [ADDR_W-1:0] offset;
    logic              in_range;

    // Decode results for the request currently presented.
    logic              dec_fault;
    logic [DATA_W-1:0] dec_rdata;
    logic              dec_side;
    logic              dec_ctrl_we;
    logic              dec_scratch_we;
    logic              dec_event_w1c;
    logic              dec_count_clr;

    logic [DATA_W-1:0] ctrl_merged;
    logic [DATA_W-1:0] scratch_merged;
    logic [DATA_W-1:0] event_clr_mask;

    assign req_ready = (state_q == CSR_RB_IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    assign offset   = req_addr - BASE_ADDR;
    assign in_range = (offset < ADDR_W'(REG_SPAN)) && (req_addr[1:0] == 2'b00);

    // Per-byte write data for strobed registers and the W1C clear mask.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_byte
            assign ctrl_merged[gi*8 +: 8]    = csr_merge_byte(ctrl_q[gi*8 +: 8],
                                                              req_wdata[gi*8 +: 8],
                                                              req_wstrb[gi]);
            assign scratch_merged[gi*8 +: 8] = csr_merge_byte(scratch_q[gi*8 +: 8],
                                                              req_wdata[gi*8 +: 8],
                                                              req_wstrb[gi]);
            assign event_clr_mask[gi*8 +: 8] = req_wstrb[gi] ? req_wdata[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    // Address decode. Reads of write-faulting or out-of-range locations return 0.
    always_comb begin
        dec_fault      = 1'b0;
        dec_rdata      = '0;
        dec_side       = 1'b0;
        dec_ctrl_we    = 1'b0;
        dec_scratch_we = 1'b0;
        dec_event_w1c  = 1'b0;
        dec_count_clr  = 1'b0;
        if (!in_range) begin
            dec_fault = 1'b1;
        end else begin
            case (offset[4:0])
                OFF_ID: begin
                    if (req_write) dec_fault = 1'b1;
                    else           dec_rdata = DATA_W'(ID_VALUE);
                end
                OFF_CTRL: begin
                    if (req_write) begin
                        if (req_priv < MIN_WR_PRIV) dec_fault   = 1'b1;
                        else                        dec_ctrl_we = 1'b1;
                    end else begin
                        dec_rdata = ctrl_q;
                    end
                end
                OFF_STATUS: begin
                    if (req_write) dec_fault = 1'b1;
                    else           dec_rdata = hw_status_i;
                end
                OFF_EVENT: begin
                    if (req_write) begin
                        dec_event_w1c = 1'b1;
                        dec_side      = 1'b1;
                    end else begin
                        dec_rdata = event_q;
                    end
                end
                OFF_SCRATCH: begin
                    if (req_write) dec_scratch_we = 1'b1;
                    else           dec_rdata      = scratch_q;
                end
                OFF_COUNT: begin
                    if (req_write) begin
                        dec_fault = 1'b1;
                    end else begin
                        dec_rdata     = count_val;
                        dec_side      = 1'b1;
                        dec_count_clr = 1'b1;
                    end
                end
                default: dec_fault = 1'b1;
            endcase
        end
    end

    // Register updates. EVENT keeps collecting pulses in every state; a set
    // and a clear on the same bit resolve to set.
    always_comb begin
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        if (accept && dec_ctrl_we)    ctrl_d    = ctrl_merged;
        if (accept && dec_scratch_we) scratch_d = scratch_merged;
        if (accept && dec_event_w1c)  event_d   = (event_q & ~event_clr_mask) | hw_event_i;
        else                          event_d   = event_q | hw_event_i;
    end

    // Responder FSM and held response registers.
    always_comb begin
        state_d           = state_q;
        rsp_rdata_d       = rsp_rdata_q;
        rsp_fault_d       = rsp_fault_q;
        rsp_side_effect_d = rsp_side_effect_q;
        case (state_q)
            CSR_RB_IDLE: begin
                if (accept) begin
                    state_d           = CSR_RB_RESP;
                    rsp_rdata_d       = dec_rdata;
                    rsp_fault_d       = dec_fault;
                    rsp_side_effect_d = dec_side;
                end
            end
            CSR_RB_RESP: begin
                if (rsp_ready) state_d = CSR_RB_IDLE;
            end
            default: state_d = CSR_RB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= CSR_RB_IDLE;
            ctrl_q            <= '0;
            scratch_q         <= '0;
            event_q           <= '0;
            rsp_rdata_q       <= '0;
            rsp_fault_q       <= 1'b0;
            rsp_side_effect_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            ctrl_q            <= ctrl_d;
            scratch_q         <= scratch_d;
            event_q           <= event_d;
            rsp_rdata_q       <= rsp_rdata_d;
            rsp_fault_q       <= rsp_fault_d;
            rsp_side_effect_q <= rsp_side_effect_d;
        end
    end

    csr_sat_counter #(
        .DATA_W (DATA_W)
    ) u_count (
        .clk     (clk),
        .rst     (rst),
        .inc     (hw_event_i != '0),
        .clr     (accept && dec_count_clr),
        .count_o (count_val)
    );

    assign rsp_valid       = (state_q == CSR_RB_RESP);
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_fault       = rsp_fault_q;
    assign rsp_side_effect = rsp_side_effect_q;
    assign ctrl_o          = ctrl_q;

endmodule

// File: tb/tb_csr_regbank_slave.sv
// ---------------------------------------------------------------------------
// tb_csr_regbank_slave
// Directed bench for csr_regbank_slave. Expected responses are queued when a
// request is driven and popped when the response appears.
// ---------------------------------------------------------------------------
module tb_csr_regbank_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [1:0]  req_priv;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        rsp_side_effect;
    logic [31:0] ctrl_o;
    logic [31:0] hw_status_i;
    logic [31:0] hw_event_i;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
        logic        side;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    csr_regbank_slave dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_wstrb       (req_wstrb),
        .req_priv        (req_priv),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_fault       (rsp_fault),
        .rsp_side_effect (rsp_side_effect),
        .ctrl_o          (ctrl_o),
        .hw_status_i     (hw_status_i),
        .hw_event_i      (hw_event_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [31:0] rd, input logic f, input logic s);
        exp_t e;
        e.rdata = rd;
        e.fault = f;
        e.side  = s;
        return e;
    endfunction

    // Pop the oldest expectation and compare it with the response on the bus.
    task automatic check_rsp(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rdata"}, rsp_rdata, e.rdata);
        check({tag, "_fault"}, 32'(rsp_fault), 32'(e.fault));
        check({tag, "_side"},  32'(rsp_side_effect), 32'(e.side));
        $display("txn %-14s rdata=%h fault=%0b side=%0b (exp %h/%0b/%0b)",
                 tag, rsp_rdata, rsp_fault, rsp_side_effect, e.rdata, e.fault, e.side);
    endtask

    // One complete transaction with rsp_ready held high. evt is driven on
    // hw_event_i during the accept cycle only.
    task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [1:0] priv, input logic [31:0] evt,
                          input logic [31:0] e_rdata, input logic e_fault,
                          input logic e_side);
        int n;
        exp_q.push_back(mk_exp(e_rdata, e_fault, e_side));
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_wstrb  = strb;
        req_priv   = priv;
        hw_event_i = evt;
        rsp_ready  = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid  = 1'b0;
        hw_event_i = '0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_rsp(tag);
    endtask

    task automatic pulse_events(input logic [31:0] evt, input int cycles);
        @(negedge clk);
        hw_event_i = evt;
        repeat (cycles) @(negedge clk);
        hw_event_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_wstrb   = '0;
        req_priv    = '0;
        rsp_ready   = 1'b0;
        hw_status_i = '0;
        hw_event_i  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'd1);
        check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_ctrl_o", ctrl_o, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);

        // ID and CTRL
        do_req("rd_id", 1'b0, 32'h00, 32'h0, 4'h0, 2'd0, 32'h0, 32'hCA5B_0001, 1'b0, 1'b0);
        do_req("wr_ctrl_p3", 1'b1, 32'h04, 32'h1122_3344, 4'b0101, 2'd3, 32'h0, 32'h0, 1'b0, 1'b0);
        check("ctrl_o_strobe", ctrl_o, 32'h0022_0044);
        do_req("wr_ctrl_p1", 1'b1, 32'h04, 32'h1122_3344, 4'b1111, 2'd1, 32'h0, 32'h0, 1'b1, 1'b0);
        check("ctrl_o_unchg", ctrl_o, 32'h0022_0044);
        do_req("rd_ctrl_p0", 1'b0, 32'h04, 32'h0, 4'h0, 2'd0, 32'h0, 32'h0022_0044, 1'b0, 1'b0);

        // STATUS
        hw_status_i = 32'hDEAD_BEEF;
        do_req("rd_status", 1'b0, 32'h08, 32'h0, 4'h0, 2'd0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // EVENT: pulse 0x5 (COUNT -> 1), clear bit 0
        pulse_events(32'h5, 1);
        do_req("w1c_ev_b0", 1'b1, 32'h0C, 32'h1, 4'hF, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        do_req("rd_ev_4", 1'b0, 32'h0C, 32'h0, 4'h0, 2'd0, 32'h0, 32'h4, 1'b0, 1'b0);
        // Clear and set of bit 2 together: set wins (COUNT -> 2)
        do_req("w1c_ev_race", 1'b1, 32'h0C, 32'h4, 4'hF, 2'd0, 32'h4, 32'h0, 1'b0, 1'b1);
        do_req("rd_ev_race", 1'b0, 32'h0C, 32'h0, 4'h0, 2'd0, 32'h0, 32'h4, 1'b0, 1'b0);
        do_req("w1c_ev_b2", 1'b1, 32'h0C, 32'h4, 4'hF, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        do_req("rd_ev_0", 1'b0, 32'h0C, 32'h0, 4'h0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);

        // COUNT read-clear
        do_req("rd_cnt_2", 1'b0, 32'h14, 32'h0, 4'h0, 2'd0, 32'h0, 32'h2, 1'b0, 1'b1);
        pulse_events(32'h1, 3);
        do_req("rd_cnt_3", 1'b0, 32'h14, 32'h0, 4'h0, 2'd0, 32'h0, 32'h3, 1'b0, 1'b1);
        do_req("rd_cnt_race", 1'b0, 32'h14, 32'h0, 4'h0, 2'd0, 32'h1, 32'h0, 1'b0, 1'b1);
        do_req("rd_cnt_1", 1'b0, 32'h14, 32'h0, 4'h0, 2'd0, 32'h0, 32'h1, 1'b0, 1'b1);

        // SCRATCH, including a zero-strobe write
        do_req("wr_scratch", 1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        do_req("wr_scr_nostb", 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);

        // Backpressure: SCRATCH read held 5 cycles, second request waits
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        req_wstrb = 4'h0;
        exp_q.push_back(mk_exp(32'hA5A5_5A5A, 1'b0, 1'b0));
        @(negedge clk);
        req_addr = 32'h00;
        exp_q.push_back(mk_exp(32'hCA5B_0001, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, 32'hA5A5_5A5A);
            check("bp_fault_side", {30'd0, rsp_fault, rsp_side_effect}, 32'd0);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        check_rsp("bp_rd_scratch");
        @(negedge clk);
        check("bp_gap_valid", 32'(rsp_valid), 32'd0);
        check("bp_gap_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check_rsp("bp_rd_id");

        // Faults leave state untouched
        do_req("rd_oob_18", 1'b0, 32'h18, 32'h0, 4'h0, 2'd3, 32'h0, 32'h0, 1'b1, 1'b0);
        do_req("rd_unal_06", 1'b0, 32'h06, 32'h0, 4'h0, 2'd3, 32'h0, 32'h0, 1'b1, 1'b0);
        do_req("wr_status", 1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF, 2'd3, 32'h0, 32'h0, 1'b1, 1'b0);
        do_req("wr_unal_12", 1'b1, 32'h12, 32'hFFFF_FFFF, 4'hF, 2'd3, 32'h0, 32'h0, 1'b1, 1'b0);
        do_req("wr_count", 1'b1, 32'h14, 32'hFFFF_FFFF, 4'hF, 2'd3, 32'h0, 32'h0, 1'b1, 1'b0);
        do_req("rd_scr_keep", 1'b0, 32'h10, 32'h0, 4'h0, 2'd0, 32'h0, 32'hA5A5_5A5A, 1'b0, 1'b0);
        check("ctrl_o_keep", ctrl_o, 32'h0022_0044);

        // Reset while a response is pending
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_ready", 32'(req_ready), 32'd0);
        check("midrst_ctrl_o", ctrl_o, 32'h0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("postrst_ready", 32'(req_ready), 32'd1);
        check("postrst_valid", 32'(rsp_valid), 32'd0);
        do_req("rd_scr_rst", 1'b0, 32'h10, 32'h0, 4'h0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        do_req("rd_cnt_rst", 1'b0, 32'h14, 32'h0, 4'h0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b1);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
